// File: rtl/lc3b_types.sv
// Shared LC-3b types: word and line-address widths plus the indirect sequencer enums.
// Pure declarations; no logic and no latency.
// Backpressure: not applicable.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [11:0] lc3b_wb_adr;

  localparam int LC3B_WORD_W   = $bits(lc3b_word);
  localparam int LC3B_OFFSET_W = $bits(lc3b_word) - $bits(lc3b_wb_adr);

  typedef enum logic [2:0] {
    IDLE,
    PTR_RD,
    IND_RD,
    IND_WR,
    DONE
  } ind_state_e;

  typedef enum logic {
    OP_LDI,
    OP_STI
  } ind_op_e;

endpackage

// File: rtl/indirect_mem_sequencer_if.sv
// Memory-side request/response bus between the sequencer and the memory.
// No storage; purely wires grouped for port readability.
// Backpressure: the memory holds mem_resp low until the access is done.
interface indirect_mem_sequencer_if
  import lc3b_types::*;
#(
  parameter int DATA_W   = LC3B_WORD_W,
  parameter int OFFSET_W = LC3B_OFFSET_W
);
  logic                       mem_read;
  logic                       mem_write;
  logic [DATA_W-OFFSET_W-1:0] mem_address;
  logic [OFFSET_W-1:0]        line_offset_out;
  logic                       mem_resp;
  logic [DATA_W-1:0]          mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, line_offset_out,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, line_offset_out,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/indirect_mem_sequencer.sv
// Turns an LDI/STI in MEM into a pointer read followed by an indirect read/write.
// Latency: plain ops pass straight through; LDI/STI take both memory waits plus one DONE cycle.
// Backpressure: stall_pipeline holds upstream until the indirect access responds.
// Optional macro INDIRECT_ALIGN_CHECK_EN: odd pointers raise ptr_fault and skip the indirect access.
module indirect_mem_sequencer
  import lc3b_types::*;
#(
  parameter int DATA_W   = LC3B_WORD_W,
  parameter int OFFSET_W = LC3B_OFFSET_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       is_ldi,
  input  logic                       is_sti,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [DATA_W-OFFSET_W-1:0] mem_address_in,
  input  logic [OFFSET_W-1:0]        line_offset_in,
  indirect_mem_sequencer_if.master   mem,
  output logic                       mem_resp_out,
  output logic                       stall_pipeline,
  output logic                       busy,
  output logic                       ptr_fault
);

  ind_state_e        state_q, state_d;
  ind_op_e           op_q, op_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;

`ifdef INDIRECT_ALIGN_CHECK_EN
  logic ptr_fault_q, ptr_fault_d;
`endif

  // State, captured op type and pointer registers; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LDI;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef INDIRECT_ALIGN_CHECK_EN
  // Fault pulse is registered so it lands in the DONE cycle that follows the bad pointer.
  always_ff @(posedge clk) begin
    if (rst) ptr_fault_q <= 1'b0;
    else     ptr_fault_q <= ptr_fault_d;
  end
  assign ptr_fault = ptr_fault_q;
`else
  assign ptr_fault = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // Next-state and memory-request muxing for each phase of the indirect sequence.
  always_comb begin
    state_d             = state_q;
    op_d                = op_q;
    ptr_d               = ptr_q;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_address     = '0;
    mem.line_offset_out = '0;
    mem_resp_out        = 1'b0;
    stall_pipeline      = 1'b0;
`ifdef INDIRECT_ALIGN_CHECK_EN
    ptr_fault_d         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        mem.mem_read        = mem_read_in;
        mem.mem_write       = mem_write_in;
        mem.mem_address     = mem_address_in;
        mem.line_offset_out = line_offset_in;
        mem_resp_out        = mem.mem_resp;
        if (is_ldi || is_sti) begin
          stall_pipeline = 1'b1;
          state_d        = PTR_RD;
          op_d           = is_ldi ? OP_LDI : OP_STI;
        end
      end
      PTR_RD: begin
        // The pointer lives at the pipeline's own address; its response is swallowed.
        mem.mem_read        = 1'b1;
        mem.mem_address     = mem_address_in;
        mem.line_offset_out = line_offset_in;
        stall_pipeline      = 1'b1;
        if (mem.mem_resp) begin
          ptr_d   = mem.mem_rdata;
          state_d = (op_q == OP_LDI) ? IND_RD : IND_WR;
`ifdef INDIRECT_ALIGN_CHECK_EN
          if (mem.mem_rdata[0]) begin
            state_d     = DONE;
            ptr_fault_d = 1'b1;
          end
`endif
        end
      end
      IND_RD, IND_WR: begin
        mem.mem_read        = (state_q == IND_RD);
        mem.mem_write       = (state_q == IND_WR);
        mem.mem_address     = ptr_q[DATA_W-1:OFFSET_W];
        mem.line_offset_out = ptr_q[OFFSET_W-1:0];
        mem_resp_out        = mem.mem_resp;
        stall_pipeline      = ~mem.mem_resp;
        if (mem.mem_resp) state_d = DONE;
      end
      DONE: begin
        // One quiet cycle lets the pipeline advance past the LDI/STI before re-arming.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_indirect_mem_sequencer.sv
module tb_indirect_mem_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        is_ldi, is_sti, mem_read_in, mem_write_in;
  logic [11:0] mem_address_in;
  logic [3:0]  line_offset_in;
  logic        mem_resp_out, stall_pipeline, busy, ptr_fault;

  int errors = 0;
  int checks = 0;
  int n_rd   = 0;
  int n_wr   = 0;
  int base_rd, base_wr;

  indirect_mem_sequencer_if #(.DATA_W(16), .OFFSET_W(4)) mb ();

  indirect_mem_sequencer #(.DATA_W(16), .OFFSET_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .is_ldi         (is_ldi),
    .is_sti         (is_sti),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_address_in (mem_address_in),
    .line_offset_in (line_offset_in),
    .mem            (mb.master),
    .mem_resp_out   (mem_resp_out),
    .stall_pipeline (stall_pipeline),
    .busy           (busy),
    .ptr_fault      (ptr_fault)
  );

  always #5 clk = ~clk;

  // Completed memory transactions as seen on the bus.
  always @(posedge clk) begin
    if (!rst && mb.mem_resp && mb.mem_read)  n_rd <= n_rd + 1;
    if (!rst && mb.mem_resp && mb.mem_write) n_wr <= n_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic rd, input logic wr,
                           input logic [11:0] a, input logic [3:0] o,
                           input logic st, input logic ro, input logic by);
    chk({tag, ".mem_read"},  32'(mb.mem_read),        32'(rd));
    chk({tag, ".mem_write"}, 32'(mb.mem_write),       32'(wr));
    chk({tag, ".addr"},      32'(mb.mem_address),     32'(a));
    chk({tag, ".offset"},    32'(mb.line_offset_out), 32'(o));
    chk({tag, ".stall"},     32'(stall_pipeline),     32'(st));
    chk({tag, ".resp_out"},  32'(mem_resp_out),       32'(ro));
    chk({tag, ".busy"},      32'(busy),               32'(by));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; is_ldi = 1'b0; is_sti = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_address_in = '0; line_offset_in = '0; mb.mem_resp = 1'b0; mb.mem_rdata = '0;
    tick(); tick();

    // Reset state and pass-through right after reset
    rst = 1'b0; mem_read_in = 1'b1; mem_address_in = 12'h055; line_offset_in = 4'h3; mb.mem_resp = 1'b1;
    #1 check_bus("reset_pt", 1, 0, 12'h055, 4'h3, 0, 1, 0);
    chk("reset_fault", 32'(ptr_fault), 32'h0);
    mem_read_in = 1'b0; mb.mem_resp = 1'b0;
    tick();

    // Plain read: response after three waiting cycles, untouched
    base_rd = n_rd;
    mem_read_in = 1'b1; mem_address_in = 12'h123; line_offset_in = 4'h4;
    for (int i = 0; i < 3; i++) begin
      #1 check_bus("plain_wait", 1, 0, 12'h123, 4'h4, 0, 0, 0);
      tick();
    end
    mb.mem_resp = 1'b1;
    #1 check_bus("plain_resp", 1, 0, 12'h123, 4'h4, 0, 1, 0);
    tick();
    mb.mem_resp = 1'b0; mem_read_in = 1'b0;
    #1 chk("plain_txns", 32'(n_rd - base_rd), 32'd1);
    tick();

    // LDI: pointer 0x4A62 -> indirect read at 0x4A6 / 0x2
    base_rd = n_rd;
    is_ldi = 1'b1; mem_read_in = 1'b1; mem_address_in = 12'h200; line_offset_in = 4'h6;
    #1 check_bus("ldi_idle", 1, 0, 12'h200, 4'h6, 1, 0, 0);
    tick();
    #1 check_bus("ldi_ptr_wait", 1, 0, 12'h200, 4'h6, 1, 0, 1);
    tick();
    mb.mem_resp = 1'b1; mb.mem_rdata = 16'h4A62;
    #1 check_bus("ldi_ptr_resp", 1, 0, 12'h200, 4'h6, 1, 0, 1);
    tick();
    mb.mem_resp = 1'b0; mb.mem_rdata = 16'hFFFF;
    #1 check_bus("ldi_ind_wait", 1, 0, 12'h4A6, 4'h2, 1, 0, 1);
    tick();
    mb.mem_resp = 1'b1;
    #1 check_bus("ldi_ind_resp", 1, 0, 12'h4A6, 4'h2, 0, 1, 1);
    tick();
    mb.mem_resp = 1'b0; is_ldi = 1'b0; mem_read_in = 1'b0;
    #1 check_bus("ldi_done", 0, 0, 12'h000, 4'h0, 0, 0, 1);
    tick();
    #1 chk("ldi_idle_again", 32'(busy), 32'h0);
    chk("ldi_txns", 32'(n_rd - base_rd), 32'd2);

    // STI: pointer 0x8010 -> indirect write at 0x801 / 0x0
    base_rd = n_rd; base_wr = n_wr;
    is_sti = 1'b1; mem_read_in = 1'b1; mem_address_in = 12'h300; line_offset_in = 4'h0;
    tick();
    mb.mem_resp = 1'b1; mb.mem_rdata = 16'h8010;
    #1 check_bus("sti_ptr_resp", 1, 0, 12'h300, 4'h0, 1, 0, 1);
    tick();
    mb.mem_resp = 1'b0;
    #1 check_bus("sti_ind_wait", 0, 1, 12'h801, 4'h0, 1, 0, 1);
    tick();
    mb.mem_resp = 1'b1;
    #1 check_bus("sti_ind_resp", 0, 1, 12'h801, 4'h0, 0, 1, 1);
    tick();
    mb.mem_resp = 1'b0; is_sti = 1'b0; mem_read_in = 1'b0;
    tick();
    #1 chk("sti_idle_again", 32'(busy), 32'h0);
    chk("sti_reads", 32'(n_rd - base_rd), 32'd1);
    chk("sti_writes", 32'(n_wr - base_wr), 32'd1);

    // Both LDI and STI asserted: LDI path wins
    is_ldi = 1'b1; is_sti = 1'b1; mem_read_in = 1'b1; mem_address_in = 12'h400; line_offset_in = 4'h1;
    tick();
    mb.mem_resp = 1'b1; mb.mem_rdata = 16'h1234;
    tick();
    mb.mem_resp = 1'b0; is_ldi = 1'b0; is_sti = 1'b0; mem_read_in = 1'b0;
    #1 check_bus("both_ind", 1, 0, 12'h123, 4'h4, 1, 0, 1);
    mb.mem_resp = 1'b1;
    tick();
    mb.mem_resp = 1'b0;
    tick();

    // Reset while the indirect read is still waiting
    is_ldi = 1'b1; mem_read_in = 1'b1; mem_address_in = 12'h010; line_offset_in = 4'h0;
    tick();
    mb.mem_resp = 1'b1; mb.mem_rdata = 16'h0500;
    tick();
    mb.mem_resp = 1'b0;
    #1 check_bus("rst_pre", 1, 0, 12'h050, 4'h0, 1, 0, 1);
    rst = 1'b1; is_ldi = 1'b0; mem_read_in = 1'b0;
    tick();
    rst = 1'b0; mem_read_in = 1'b1; mem_address_in = 12'h077; line_offset_in = 4'h5;
    #1 check_bus("rst_mid", 1, 0, 12'h077, 4'h5, 0, 0, 0);
    chk("rst_mid_fault", 32'(ptr_fault), 32'h0);
    mem_read_in = 1'b0;
    tick();

    // Odd pointer 0x3001
    base_rd = n_rd;
    is_ldi = 1'b1; mem_read_in = 1'b1; mem_address_in = 12'h020; line_offset_in = 4'h0;
    tick();
    mb.mem_resp = 1'b1; mb.mem_rdata = 16'h3001;
    tick();
    mb.mem_resp = 1'b0; is_ldi = 1'b0; mem_read_in = 1'b0;
`ifdef INDIRECT_ALIGN_CHECK_EN
    #1 check_bus("align_done", 0, 0, 12'h000, 4'h0, 0, 0, 1);
    chk("align_fault_pulse", 32'(ptr_fault), 32'h1);
    tick();
    #1 chk("align_fault_clear", 32'(ptr_fault), 32'h0);
    chk("align_idle", 32'(busy), 32'h0);
    chk("align_txns", 32'(n_rd - base_rd), 32'd1);
`else
    #1 check_bus("odd_ind", 1, 0, 12'h300, 4'h1, 1, 0, 1);
    chk("odd_no_fault", 32'(ptr_fault), 32'h0);
    mb.mem_resp = 1'b1;
    tick();
    mb.mem_resp = 1'b0;
    tick();
    #1 chk("odd_idle", 32'(busy), 32'h0);
    chk("odd_txns", 32'(n_rd - base_rd), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/indirect_mem_sequencer.md
INDIRECT_MEM_SEQUENCER -- requirements
Module: indirect_mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, 16, memory word and pointer width in bits.
REQ-002 SHALL have parameter OFFSET_W, 4, line-offset width; line address width is DATA_W-OFFSET_W.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL have port is_ldi (input, 1): current MEM-stage instruction is LDI.
REQ-005 SHALL have port is_sti (input, 1): current MEM-stage instruction is STI.
REQ-006 SHALL have ports mem_read_in and mem_write_in (input, 1 each): pipeline request.
REQ-007 SHALL have ports mem_address_in (input, DATA_W-OFFSET_W) and line_offset_in (input, OFFSET_W): pipeline address.
REQ-008 SHALL have ports mem_resp (input, 1) and mem_rdata (input, DATA_W): memory response.
REQ-009 SHALL have ports mem_read, mem_write (output, 1 each), mem_address (output, DATA_W-OFFSET_W) and line_offset_out (output, OFFSET_W): memory request.
REQ-010 SHALL have port mem_resp_out (output, 1): response forwarded to pipeline.
REQ-011 SHALL have port stall_pipeline (output, 1): hold upstream stages.
REQ-012 SHALL have port busy (output, 1): FSM not IDLE.
REQ-013 SHALL have port ptr_fault (output, 1): one-cycle pulse on misaligned pointer (REQ-030).

Function
REQ-014 FSM states SHALL be IDLE, PTR_RD, IND_RD, IND_WR, DONE.
REQ-015 In IDLE, outputs SHALL pass through mem_*_in/line_offset_in and mem_resp_out SHALL equal mem_resp.
REQ-016 In IDLE, if is_ldi or is_sti is 1, then next state SHALL be PTR_RD; is_ldi wins if both are 1.
REQ-017 Captured op type SHALL be latched on IDLE exit and held until IDLE is re-entered.
REQ-018 PTR_RD SHALL drive mem_read=1 and mem_write=0 at the pipeline address, with mem_resp_out=0.
REQ-019 On mem_resp in PTR_RD, mem_rdata SHALL be captured into ptr_q, and only in that cycle.
REQ-020 Next state after PTR_RD SHALL be IND_RD for LDI and IND_WR for STI.
REQ-021 IND_RD and IND_WR SHALL drive address ptr_q[DATA_W-1:OFFSET_W] and offset ptr_q[OFFSET_W-1:0].
REQ-022 IND_RD SHALL drive read=1/write=0; IND_WR SHALL drive read=0/write=1.
REQ-023 In IND_RD/IND_WR, mem_resp_out SHALL equal mem_resp; on mem_resp, next state SHALL be DONE.
REQ-024 DONE SHALL drive no request, stall_pipeline=0 and mem_resp_out=0, and SHALL return to IDLE after one cycle, ignoring is_ldi/is_sti.
REQ-025 stall_pipeline SHALL be 1 when (IDLE and (is_ldi or is_sti)), or in PTR_RD, or in IND_* while mem_resp=0; otherwise 0.
REQ-026 Each state SHALL wait indefinitely for mem_resp; no timeout.
REQ-027 An LDI/STI SHALL produce exactly two memory transactions; a non-indirect op SHALL produce one, untouched.

Reset
REQ-028 rst SHALL force state IDLE and clear ptr_q, op type and ptr_fault to 0, overriding a transaction in progress.
REQ-029 In the cycle after rst, outputs SHALL be IDLE pass-through.

Configuration
REQ-030 When INDIRECT_ALIGN_CHECK_EN is defined, a captured pointer with bit0=1 SHALL pulse ptr_fault for one cycle, skip IND_*, and go to DONE.
REQ-031 When INDIRECT_ALIGN_CHECK_EN is undefined, ptr_fault SHALL be tied 0 and no alignment logic SHALL exist.

Structure
REQ-032 The state enum and the indirect-op type enum SHALL live in lc3b_types.
REQ-033 DATA_W/OFFSET_W defaults SHALL match the lc3b_word and lc3b_wb_adr widths in lc3b_types.
REQ-034 The module SHALL be flat; no sub-module.

Verification
REQ-035 Plain read: addr 0x123/off 0x4, resp after 3 cycles -> one transaction; stall=0 throughout; mem_resp_out pulses once.
REQ-036 LDI: ptr read returns 0x4A62 -> second read at addr 0x4A6, off 0x2; stall held until that resp; exactly two reads.
REQ-037 STI: ptr 0x8010 -> second access is write at addr 0x801, off 0x0; mem_resp_out=0 on the first resp and 1 on the second.
REQ-038 rst asserted in IND_RD with resp pending -> next cycle IDLE, pass-through, stall=0.
REQ-039 With INDIRECT_ALIGN_CHECK_EN, LDI pointer 0x3001 -> ptr_fault pulses once; no second access; DONE then IDLE.
REQ-040 is_ldi=is_sti=1 together -> LDI path taken.
